// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential multiplier
// Purpose: FSM state encoding, step-count helpers and the operand magnitude
// function used when operands are captured.
// Ports: none (package).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest operand abs_n can handle; the top refuses larger N.
  localparam int MAX_W = 64;

  // Number of CALC steps for an n-bit operand retiring k bits per step.
  function automatic int steps(input int n, input int k);
    return n / k;
  endfunction

  // Step-counter width able to hold 0..steps.
  function automatic int cnt_w(input int n, input int k);
    return $clog2(n / k + 1);
  endfunction

  // Magnitude of an n-bit operand held in the low bits of v. In two's
  // complement mode a set MSB is negated; -2^(n-1) maps onto 2^(n-1),
  // which is still representable as an n-bit unsigned value.
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] v,
                                             input int n, input logic tc);
    logic [MAX_W-1:0] mask;
    mask = (n >= MAX_W) ? '1 : ((MAX_W'(1) << n) - MAX_W'(1));
    if (tc && v[n-1]) return (~v + MAX_W'(1)) & mask;
    return v & mask;
  endfunction

endpackage

// File: rtl/pp_gen.sv
// rtl/pp_gen.sv - N x K partial-product generator
// Purpose: combinational |a| x digit product, N+K bits wide. With K=1 this
// collapses to an AND of the multiplicand with a single bit.
// Ports:
//   a      in  N    operand magnitude
//   digit  in  K    next K multiplier bits
//   pp     out N+K  partial product
module pp_gen #(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic [N-1:0]   a,
  input  logic [K-1:0]   digit,
  output logic [N+K-1:0] pp
);

  assign pp = (N+K)'(a) * (N+K)'(digit);

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier with start/done handshake
// Purpose: multiplies two N-bit operands (signed or unsigned per operation),
// retiring K multiplier bits per cycle; result valid N/K+1 cycles after start.
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   launch an operation (ignored while busy)
//   tc     in   1   1 = two's complement operands, 0 = unsigned
//   a      in   N   multiplicand
//   b      in   N   multiplier
//   out    out  2N  product register, held until the next result
//   busy   out  1   operation in progress
//   done   out  1   one-cycle pulse when out has been updated
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 16,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           tc,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] out,
  output logic           busy,
  output logic           done
);

  localparam int STEPS = steps(N, K);
  localparam int CW    = cnt_w(N, K);
  localparam int W     = 2 * N + K;

  if (N < 2) begin : g_bad_n
    $error("seq_multiplier: N must be at least 2");
  end
  if (!(K == 1 || K == 2 || K == 4)) begin : g_bad_k
    $error("seq_multiplier: K must be 1, 2 or 4");
  end
  if (N % K != 0) begin : g_bad_nk
    $error("seq_multiplier: N must be a multiple of K");
  end
  if (N > MAX_W) begin : g_too_wide
    $error("seq_multiplier: N exceeds supported width");
  end

  state_t state, state_nxt;
  logic   load, step, fix;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_sh;
  logic           neg;
  logic [W-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [N+K-1:0] pp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == CW'(STEPS - 1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        fix       = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  pp_gen #(.N(N), .K(K)) u_pp_gen (
    .a     (a_mag),
    .digit (b_sh[K-1:0]),
    .pp    (pp)
  );

  // The partial product is added at bit N and the whole accumulator shifts
  // right K each step, so after STEPS steps the low 2N bits hold |a|*|b|.
  // The K spare top bits absorb the carry of each add before the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      done  <= 1'b0;
      acc   <= '0;
      a_mag <= '0;
      b_sh  <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= fix;
      if (load) begin
        a_mag <= N'(abs_n(MAX_W'(a), N, tc));
        b_sh  <= N'(abs_n(MAX_W'(b), N, tc));
        neg   <= tc & (a[N-1] ^ b[N-1]);
        acc   <= '0;
        cnt   <= '0;
      end
      if (step) begin
        acc  <= (acc + {pp, {N{1'b0}}}) >> K;
        b_sh <= b_sh >> K;
        cnt  <= cnt + CW'(1);
      end
      if (fix) begin
        out <= neg ? -acc[2*N-1:0] : acc[2*N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - scoreboard bench for seq_multiplier
module tb_seq_multiplier;

  localparam int N = 16;
  localparam int K = 2;
  localparam int S = N / K;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           start = 1'b0;
  logic           tc    = 1'b0;
  logic [N-1:0]   a     = '0;
  logic [N-1:0]   b     = '0;
  logic [2*N-1:0] out;
  logic           busy;
  logic           done;

  seq_multiplier #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .tc    (tc),
    .a     (a),
    .b     (b),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [2*N-1:0] p;
    int             t;
  } exp_t;

  exp_t           q[$];
  int             errs    = 0;
  int             checks  = 0;
  logic           mon_en  = 1'b0;
  logic [2*N-1:0] exp_out = '0;

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x,
                                             input logic [N-1:0] y,
                                             input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'(x);
      sy = longint'(y);
    end
    return (2*N)'(sx * sy);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic eb, ed;
    if (mon_en) begin
      eb = (q.size() > 0) && (edges < q[0].t);
      ed = (q.size() > 0) && (edges == q[0].t);
      chk("busy", 64'(busy), 64'(eb));
      chk("done", 64'(done), 64'(ed));
      if (ed) begin
        exp_out = q[0].p;
        void'(q.pop_front());
      end
      chk("out", 64'(out), 64'(exp_out));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    a     = x;
    b     = y;
    tc    = s;
    start = 1'b1;
    tick();
    q.push_back('{p: ref_mul(x, y, s), t: edges + S + 1});
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    tc    = 1'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < S + 4) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL %s: done=%b after %0d cycles, required 1 within %0d", name, done, n, S + 4);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [N-1:0] x, y;
    rst = 1'b1;
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    repeat (20) tick();

    issue(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done("unsigned_max");
    chk("unsigned_max", 64'(out), 64'h0000_0000_FFFE_0001);
    tick();

    issue(16'hFFFD, 16'h0007, 1'b1);
    wait_done("signed_neg");
    chk("signed_neg", 64'(out), 64'h0000_0000_FFFF_FFEB);
    issue(16'h8000, 16'h8000, 1'b1);
    wait_done("signed_min_sq");
    chk("signed_min_sq", 64'(out), 64'h0000_0000_4000_0000);
    tick();

    issue(16'd1234, 16'd77, 1'b0);
    tick();
    tick();
    tick();
    a     = 16'h7777;
    b     = 16'h5555;
    tc    = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_done("start_ignored");
    chk("start_ignored", 64'(out), 64'd95018);
    tick();

    issue(16'd300, 16'd5, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    q.delete();
    exp_out = '0;
    rst     = 1'b0;
    chk("rst_mid_out", 64'(out), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (S + 3) tick();
    issue(16'hABCD, 16'h1234, 1'b0);
    wait_done("after_rst");
    chk("after_rst", 64'(out), 64'h0000_0000_0C37_4FA4);
    tick();

    issue(16'h0000, 16'hFFFF, 1'b1);
    wait_done("zero_op");
    chk("zero_op", 64'(out), 64'd0);
    tick();

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       x = '0;
        1:       x = 16'h8000;
        2:       x = 16'hFFFF;
        default: x = N'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       y = '0;
        1:       y = 16'h8000;
        2:       y = 16'h7FFF;
        default: y = N'($urandom);
      endcase
      issue(x, y, 1'($urandom));
      wait_done("random");
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    repeat (S + 4) tick();
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
